// File: rtl/mem_pkg.sv
// Shared types and constants for the DRAM arbiter: FSM states, requester ids
// and the legal wait-cycle range.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;
  localparam int CNT_W   = 3;

endpackage

// File: rtl/dram_arb_pick.sv
// Combinational requester picker; gnt_oh[0] = fetch, gnt_oh[1] = LSU.
// Round-robin tie-breaking is compiled in when DRAM_ARB_RR_EN is defined.
module dram_arb_pick
  import mem_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_served,
  output logic [1:0] gnt_oh
);

`ifdef DRAM_ARB_RR_EN
  always_comb begin
    gnt_oh = 2'b00;
    if (i_req && d_req) begin
      // The port that was not served last wins a tie.
      gnt_oh = (last_served == PORT_LS) ? 2'b01 : 2'b10;
    end else begin
      gnt_oh = {d_req, i_req};
    end
  end
`else
  logic unused_last_served;
  assign unused_last_served = last_served;

  always_comb begin
    gnt_oh = 2'b00;
    if (d_req) gnt_oh = 2'b10;
    else if (i_req) gnt_oh = 2'b01;
  end
`endif

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single-port DRAM between the fetch and LSU ports, one access at a
// time (IDLE -> ACCESS x LAT -> RESP). DRAM_ARB_RR_EN selects round-robin ties.
module dram_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 20,
  parameter int LAT       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [31:0]          i_rdata,
  input  logic                 d_req,
  input  logic [31:0]          d_addr,
  input  logic [3:0]           d_we,
  input  logic [31:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  output logic [ADDR_BITS-1:0] ram_a,
  output logic [3:0]           ram_we,
  output logic [31:0]          ram_d,
  input  logic [31:0]          ram_spo
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
    $error("dram_arbiter: LAT out of range");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 port_q, port_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          i_rdata_q, i_rdata_d;
  logic [31:0]          d_rdata_q, d_rdata_d;
  logic                 last_served;
  logic [1:0]           gnt_oh;
  logic                 idle, final_cyc;

`ifdef DRAM_ARB_RR_EN
  logic last_q, last_d;
  assign last_served = last_q;
`else
  assign last_served = PORT_LS;
`endif

  dram_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_served (last_served),
    .gnt_oh      (gnt_oh)
  );

  // Byte-offset bits and bits above the word address wrap silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[31:ADDR_BITS+2],
                              d_addr[1:0], d_addr[31:ADDR_BITS+2]};

  assign idle      = (state_q == ST_IDLE);
  assign final_cyc = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign i_gnt     = idle && !rst && gnt_oh[0];
  assign d_gnt     = idle && !rst && gnt_oh[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef DRAM_ARB_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (d_gnt) begin
          port_d  = PORT_LS;
          addr_d  = d_addr[ADDR_BITS+1:2];
          we_d    = d_we;
          wdata_d = d_wdata;
        end else if (i_gnt) begin
          port_d  = PORT_IF;
          addr_d  = i_addr[ADDR_BITS+1:2];
          we_d    = 4'b0000;
          wdata_d = 32'h0;
        end
        if (d_gnt || i_gnt) begin
          cnt_d   = CNT_INIT;
          state_d = ST_ACCESS;
`ifdef DRAM_ARB_RR_EN
          last_d  = d_gnt ? PORT_LS : PORT_IF;
`endif
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          // Combinational read sampled before the write edge: writes return the old word.
          if (port_q == PORT_LS) d_rdata_d = ram_spo;
          else                   i_rdata_d = ram_spo;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      port_q    <= PORT_IF;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef DRAM_ARB_RR_EN
      last_q    <= PORT_LS;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef DRAM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign ram_a    = addr_q;
  assign ram_d    = wdata_q;
  assign ram_we   = (final_cyc && !rst) ? we_q : 4'b0000;
  assign i_rvalid = (state_q == ST_RESP) && (port_q == PORT_IF);
  assign d_rvalid = (state_q == ST_RESP) && (port_q == PORT_LS);
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
